bloom_line_scheduler: RTL and testbench

Sequencer and arbiter for the time-sliced Bloom filter line memory. It arbitrates between an insert requester (data path) and a query requester (ack path), performs one read-ageing-modify-write per request on the line SRAM, and owns the free-running bucket/loop time base. The block drives an external line-ageing updater with the fetched line and the current time, and takes back the aged line. It sits between the hash stage and the line SRAM.

---
 rtl/bloom_line_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_bloom_line_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_line_scheduler.sv
// bloom_line_scheduler: arbitrates insert/query requests onto the Bloom line SRAM,
// runs one read-age-modify-write per request, and owns the bucket/loop time base.
module bloom_line_scheduler #(
  parameter int DATA_WIDTH      = 72,
  parameter int NUM_BUCKETS     = 12,
  parameter int BUCKET_SZ       = 4,
  parameter int BLOOM_INIT_POS  = 16,
  parameter int BITS_SHIFT      = $clog2(NUM_BUCKETS),
  parameter int ADDR_WIDTH      = 10,
  parameter int CLKS_PER_BUCKET = 1000,
  localparam int BIT_W          = $clog2(BUCKET_SZ),
  localparam int LOOP_W         = BLOOM_INIT_POS - BITS_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [ADDR_WIDTH-1:0] ins_addr,
  input  logic [BIT_W-1:0]      ins_bit,
  output logic                  ins_done,
  input  logic                  qry_valid,
  output logic                  qry_ready,
  input  logic [ADDR_WIDTH-1:0] qry_addr,
  input  logic [BIT_W-1:0]      qry_bit,
  output logic                  qry_done,
  output logic                  qry_hit,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_vld,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] age_data,
  input  logic [DATA_WIDTH-1:0] age_result,
  output logic [BITS_SHIFT-1:0] cur_bucket_op,
  output logic [LOOP_W-1:0]     cur_loop_op
);

  localparam int TICK_W     = $clog2(CLKS_PER_BUCKET);
  localparam int NUM_SLICES = (DATA_WIDTH - BLOOM_INIT_POS) / BUCKET_SZ;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_UPD, S_WR} state_t;

  typedef struct packed {
    logic                  is_qry;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BIT_W-1:0]      bsel;
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BITS_SHIFT-1:0] bucket_q, bucket_d, bucket_op_q, bucket_op_d;
  logic [LOOP_W-1:0]     loop_q, loop_d, loop_op_q, loop_op_d;
  logic [DATA_WIDTH-1:0] age_q, age_d, line_q, line_d;
  logic                  hit_q, hit_d, prio_q, prio_d, run_q;
  logic                  gnt_ins, gnt_qry, slice_hit;

  assign age_data      = age_q;
  assign cur_bucket_op = bucket_op_q;
  assign cur_loop_op   = loop_op_q;

  // Free-running time base: tick -> bucket -> loop, independent of the FSM.
  always_comb begin
    tick_d   = tick_q + TICK_W'(1);
    bucket_d = bucket_q;
    loop_d   = loop_q;
    if (tick_q == TICK_W'(CLKS_PER_BUCKET - 1)) begin
      tick_d = '0;
      if (bucket_q == BITS_SHIFT'(NUM_BUCKETS - 1)) begin
        bucket_d = '0;
        loop_d   = loop_q + LOOP_W'(1);
      end else begin
        bucket_d = bucket_q + BITS_SHIFT'(1);
      end
    end
  end

  // Round-robin grant in IDLE; prio_q=0 favours insert. run_q keeps readys low until out of reset.
  always_comb begin
    gnt_ins = 1'b0;
    gnt_qry = 1'b0;
    if (state_q == S_IDLE && run_q) begin
      if (ins_valid && qry_valid) begin
        gnt_ins = ~prio_q;
        gnt_qry = prio_q;
      end else begin
        gnt_ins = ins_valid;
        gnt_qry = qry_valid;
      end
    end
  end

  // FSM next state: one read-age-modify-write per accepted request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_ins || gnt_qry) state_d = S_RD;
      S_RD:    state_d = S_WAIT;
      S_WAIT:  if (mem_rd_vld) state_d = S_UPD;
      S_UPD:   state_d = S_WR;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: memory strobes and done pulses are decoded from the state alone.
  always_comb begin
    ins_ready   = gnt_ins;
    qry_ready   = gnt_qry;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    ins_done    = 1'b0;
    qry_done    = 1'b0;
    qry_hit     = 1'b0;
    case (state_q)
      S_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = op_q.addr;
      end
      S_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = op_q.addr;
        mem_wr_data = line_q;
        ins_done    = ~op_q.is_qry;
        qry_done    = op_q.is_qry;
        qry_hit     = op_q.is_qry & hit_q;
      end
      default: ;
    endcase
  end

  // Datapath: latch request and time on accept, capture read data, age and modify the line.
  always_comb begin
    op_d        = op_q;
    bucket_op_d = bucket_op_q;
    loop_op_d   = loop_op_q;
    age_d       = age_q;
    line_d      = line_q;
    hit_d       = hit_q;
    prio_d      = prio_q;
    slice_hit   = 1'b0;
    // Query hit looks at the same bit position in every slice of the aged line.
    for (int k = 0; k < NUM_SLICES; k++)
      slice_hit = slice_hit |
        (|(age_result & (ONE << (BLOOM_INIT_POS + k * BUCKET_SZ + int'(op_q.bsel)))));
    if (gnt_ins || gnt_qry) begin
      op_d.is_qry = gnt_qry;
      op_d.addr   = gnt_qry ? qry_addr : ins_addr;
      op_d.bsel   = gnt_qry ? qry_bit : ins_bit;
      bucket_op_d = bucket_q;
      loop_op_d   = loop_q;
      prio_d      = gnt_ins;
    end
    if (state_q == S_WAIT && mem_rd_vld) age_d = mem_rd_data;
    if (state_q == S_UPD) begin
      hit_d  = op_q.is_qry & slice_hit;
      line_d = age_result;
      // Inserts land in the newest slice, which sits at the MSB end.
      if (!op_q.is_qry)
        line_d = age_result | (ONE << (DATA_WIDTH - BUCKET_SZ + int'(op_q.bsel)));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Time base and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      tick_q      <= '0;
      bucket_q    <= '0;
      loop_q      <= '0;
      op_q        <= '0;
      bucket_op_q <= '0;
      loop_op_q   <= '0;
      age_q       <= '0;
      line_q      <= '0;
      hit_q       <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      tick_q      <= tick_d;
      bucket_q    <= bucket_d;
      loop_q      <= loop_d;
      op_q        <= op_d;
      bucket_op_q <= bucket_op_d;
      loop_op_q   <= loop_op_d;
      age_q       <= age_d;
      line_q      <= line_d;
      hit_q       <= hit_d;
      prio_q      <= prio_d;
    end
  end

endmodule

// File: tb/tb_bloom_line_scheduler.sv
// Directed bench for bloom_line_scheduler: scoreboard of expected writes/dones,
// behavioural line SRAM with configurable latency, and a stamp-refreshing ageing model.
module tb_bloom_line_scheduler;
  localparam int DW = 72, AW = 10, CPB = 4, NB = 12;
  localparam logic [DW-1:0] ONE = DW'(1);

  typedef struct { logic [AW-1:0] addr; logic [1:0] b; int start; } req_t;
  typedef struct {
    logic is_ins; logic [AW-1:0] addr; logic hit; logic [DW-1:0] wr;
    logic [3:0] bkt; logic [11:0] lp; int t_acc; int lat;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b1;
  logic ins_valid, ins_ready, ins_done, qry_valid, qry_ready, qry_done, qry_hit;
  logic [AW-1:0] ins_addr, qry_addr, mem_addr;
  logic [1:0] ins_bit, qry_bit;
  logic mem_rd_en, mem_rd_vld, mem_wr_en;
  logic [DW-1:0] mem_rd_data, mem_wr_data, age_data, age_result;
  logic [3:0] cur_bucket_op;
  logic [11:0] cur_loop_op;

  bloom_line_scheduler #(.CLKS_PER_BUCKET(CPB)) dut (
    .clk(clk), .reset_n(reset_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_addr(ins_addr), .ins_bit(ins_bit),
    .ins_done(ins_done),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_addr(qry_addr), .qry_bit(qry_bit),
    .qry_done(qry_done), .qry_hit(qry_hit),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_vld(mem_rd_vld), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .age_data(age_data), .age_result(age_result),
    .cur_bucket_op(cur_bucket_op), .cur_loop_op(cur_loop_op)
  );

  // Ageing updater model: keeps the Bloom field, refreshes the stamp with the op time.
  assign age_result = {age_data[DW-1:16], cur_bucket_op, cur_loop_op};

  always #5 clk = ~clk;

  int tb_cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;

  // Line SRAM: read data returns lat cycles after mem_rd_en, junk otherwise.
  logic [DW-1:0] mem [int];
  int lat = 1;
  initial begin : responder
    int due;
    int a;
    due = -1; a = 0;
    mem_rd_vld = 1'b0; mem_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_rd_vld  = reset_n && (tb_cyc == due);
      mem_rd_data = mem_rd_vld ? (mem.exists(a) ? mem[a] : '0) : DW'({$urandom, $urandom, $urandom});
      @(negedge clk);
      if (!reset_n) due = -1;
      else begin
        if (mem_rd_en) begin due = tb_cyc + lat; a = int'(mem_addr); end
        if (mem_wr_en) mem[int'(mem_addr)] = mem_wr_data;
      end
    end
  end

  int checks = 0, errors = 0;
  req_t pend_i[$], pend_q[$];
  exp_t sb[$];
  logic [DW-1:0] ref_mem [int];
  logic [3:0] glog;
  int ngnt;
  logic [DW-1:0] last_wr;
  logic last_hit;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] outs();
    return 192'({ins_ready, qry_ready, ins_done, qry_done, qry_hit, mem_rd_en, mem_wr_en,
                 mem_addr, mem_wr_data, age_data, cur_bucket_op, cur_loop_op});
  endfunction

  // Called on the negedge before an accepting edge: predict the write for this request.
  task automatic accept(input logic is_ins, input req_t r);
    exp_t e;
    logic [DW-1:0] line;
    int n;
    n = tb_cyc;
    e.is_ins = is_ins; e.addr = r.addr; e.t_acc = n; e.lat = lat;
    e.bkt = 4'((n / CPB) % NB);
    e.lp  = 12'((n / (CPB * NB)) % 4096);
    line = ref_mem.exists(int'(r.addr)) ? ref_mem[int'(r.addr)] : '0;
    line[15:0] = {e.bkt, e.lp};
    e.hit = 1'b0;
    for (int k = 0; k < 14; k++) e.hit = e.hit | (|(line & (ONE << (16 + 4 * k + int'(r.b)))));
    if (is_ins) begin
      line  = line | (ONE << (DW - 4 + int'(r.b)));
      e.hit = 1'b0;
    end
    e.wr = line;
    sb.push_back(e);
    glog = {glog[2:0], ~is_ins};
    ngnt++;
  endtask

  task automatic step();
    exp_t e;
    chk("ready_excl", 192'((ins_ready && (qry_ready || !ins_valid)) || (qry_ready && !qry_valid)), 192'(0));
    if (mem_rd_en) begin
      if (sb.size() == 0) chk("rd_unexpected", 192'(mem_rd_en), 192'(0));
      else begin
        chk("rd_cycle", 192'(tb_cyc), 192'(sb[0].t_acc + 1));
        chk("rd_addr", 192'(mem_addr), 192'(sb[0].addr));
      end
    end
    if (mem_wr_en || ins_done || qry_done) begin
      if (sb.size() == 0) chk("wr_unexpected", 192'({mem_wr_en, ins_done, qry_done}), 192'(0));
      else begin
        e = sb.pop_front();
        chk("wr_cycle", 192'(tb_cyc), 192'(e.t_acc + 3 + e.lat));
        chk("done_kind", 192'({mem_wr_en, ins_done, qry_done}), 192'({1'b1, e.is_ins, ~e.is_ins}));
        chk("wr_addr", 192'(mem_addr), 192'(e.addr));
        chk("wr_data", 192'(mem_wr_data), 192'(e.wr));
        chk("qry_hit", 192'(qry_hit), 192'(e.hit));
        chk("bucket_op", 192'(cur_bucket_op), 192'(e.bkt));
        chk("loop_op", 192'(cur_loop_op), 192'(e.lp));
        ref_mem[int'(e.addr)] = e.wr;
        last_wr  = mem_wr_data;
        last_hit = qry_hit;
      end
    end
    if (ins_valid && ins_ready) accept(1'b1, pend_i.pop_front());
    else if (qry_valid && qry_ready) accept(1'b0, pend_q.pop_front());
  endtask

  // Drive pending requests until all are accepted and completed (entered at posedge+1).
  task automatic run(input int max_cyc);
    int n;
    n = 0;
    while ((pend_i.size() + pend_q.size() + sb.size()) > 0 && n < max_cyc) begin
      ins_valid = 1'b0; qry_valid = 1'b0;
      if (pend_i.size() > 0 && tb_cyc >= pend_i[0].start) begin
        ins_valid = 1'b1; ins_addr = pend_i[0].addr; ins_bit = pend_i[0].b;
      end
      if (pend_q.size() > 0 && tb_cyc >= pend_q[0].start) begin
        qry_valid = 1'b1; qry_addr = pend_q[0].addr; qry_bit = pend_q[0].b;
      end
      @(negedge clk); step();
      @(posedge clk); #1; n++;
    end
    chk("run_timeout", 192'(n >= max_cyc), 192'(0));
    ins_valid = 1'b0; qry_valid = 1'b0;
    pend_i.delete(); pend_q.delete(); sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    ins_valid = 0; qry_valid = 0; ins_addr = '0; qry_addr = '0; ins_bit = '0; qry_bit = '0;
    glog = '0; ngnt = 0; last_wr = '0; last_hit = 1'b0;

    // Reset: every output low even with both requesters valid.
    #2 reset_n = 1'b0;
    ins_valid = 1; qry_valid = 1;
    @(negedge clk); chk("reset_outputs", outs(), 192'(0));
    ins_valid = 0; qry_valid = 0;
    @(posedge clk); #1 reset_n = 1'b1;

    // Time base: bucket 2 at clock 11, bucket 11 loop 0 at 47, bucket 0 loop 1 at 48.
    lat = 1;
    pend_q.push_back('{10'd3, 2'd0, 11});
    pend_q.push_back('{10'd3, 2'd0, 47});
    run(200);
    do_reset();
    pend_q.push_back('{10'd3, 2'd0, 48});
    pend_q.push_back('{10'd3, 2'd0, 95});
    run(200);

    // Insert on an all-zero line, then queries on the same address.
    pend_i.push_back('{10'd5, 2'd2, 0});
    run(50);
    chk("ins_bit70", 192'(last_wr[70]), 192'(1));
    pend_q.push_back('{10'd5, 2'd2, 0});
    run(50);
    chk("qry_hit_set", 192'(last_hit), 192'(1));
    pend_q.push_back('{10'd5, 2'd1, 0});
    run(50);
    chk("qry_hit_clear", 192'(last_hit), 192'(0));

    // Both sides held valid: grants must alternate starting with insert.
    do_reset();
    glog = '0; ngnt = 0;
    pend_i.push_back('{10'd9, 2'd0, 0});
    pend_i.push_back('{10'd10, 2'd3, 0});
    pend_q.push_back('{10'd5, 2'd2, 0});
    pend_q.push_back('{10'd11, 2'd1, 0});
    run(100);
    chk("grant_order", 192'({ngnt[7:0], glog}), 192'({8'd4, 4'b0101}));

    // L=3, accept aligned so a bucket tick falls inside WAIT.
    lat = 3;
    pend_i.push_back('{10'd20, 2'd3, ((tb_cyc + 4) / CPB) * CPB});
    run(100);
    pend_q.push_back('{10'd20, 2'd3, 0});
    run(100);
    chk("l3_qry_hit", 192'(last_hit), 192'(1));

    // Reset during WAIT: op abandoned, outputs zero, next op normal.
    lat = 5;
    ins_valid = 1; ins_addr = 10'd7; ins_bit = 2'd1;
    @(negedge clk); chk("midrst_accept", 192'(ins_ready), 192'(1));
    @(posedge clk); #1 ins_valid = 0;
    @(negedge clk); chk("midrst_rd", 192'(mem_rd_en), 192'(1));
    @(posedge clk); #2 reset_n = 1'b0;
    ins_valid = 1; qry_valid = 1;
    repeat (4) begin
      @(negedge clk); chk("midrst_outputs", outs(), 192'(0));
    end
    ins_valid = 0; qry_valid = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    lat = 1;
    pend_i.push_back('{10'd7, 2'd0, 0});
    run(50);
    chk("post_rst_line", 192'(last_wr), 192'((ONE << 68) | DW'(16'h0000)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
